oam_dma: RTL and testbench

// - Sprite-OAM DMA controller. Sequences the $4014 transfer: on a CPU write of page P it halts the CPU,

---
 rtl/ppu_pkg.sv | 23 ++
 rtl/oam_dma.sv | 92 +++++++++
 tb/tb_oam_dma.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU register map and OAM DMA types.
// Address constants used by the PPU register decode and the $4014 sprite DMA.
package ppu_pkg;

  localparam logic [15:0] PPUCTRL_ADDR   = 16'h2000;
  localparam logic [15:0] PPUMASK_ADDR   = 16'h2001;
  localparam logic [15:0] PPUSTATUS_ADDR = 16'h2002;
  localparam logic [15:0] PPUSCROLL_ADDR = 16'h2005;
  localparam logic [15:0] PPUADDR_ADDR   = 16'h2006;
  localparam logic [15:0] PPUDATA_ADDR   = 16'h2007;

  localparam logic [15:0] DMA_REG_ADDR   = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR   = 16'h2004;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a $4014 write halts the CPU for 513/514 CPU cycles while 256 bytes move to $2004.
// Advances only on cpu_en; with cpu_en low every register and output holds.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = ppu_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = ppu_pkg::OAMDATA_ADDR,
  parameter int          NBYTES       = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [15:0] reg_addr,
  input  logic        reg_wr,
  input  logic [7:0]  reg_data_i,
  input  logic [7:0]  bus_data_i,
  output logic        dma_halt,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_data_o,
  output logic        dma_done
);
  import ppu_pkg::*;

  // The byte counter is 8 bits wide, so NBYTES has to stay 256.
  localparam logic [7:0] LAST_CNT = 8'(NBYTES - 1);

  dma_state_t state;
  logic       parity;
  logic [7:0] page;
  logic [7:0] cnt;
  logic [7:0] latch;
  logic       trigger;

  assign trigger = reg_wr && (reg_addr == DMA_REG_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DMA_IDLE;
      parity <= 1'b0;
      page   <= 8'h00;
      cnt    <= 8'h00;
      latch  <= 8'h00;
    end else if (cpu_en) begin
      parity <= ~parity;
      case (state)
        DMA_IDLE: begin
          if (trigger) begin
            page  <= reg_data_i;
            cnt   <= 8'h00;
            state <= DMA_HALT;
          end
        end
        // Reads must land on get (parity 0) cycles; an odd start costs one extra cycle.
        DMA_HALT:  state <= parity ? DMA_READ : DMA_ALIGN;
        DMA_ALIGN: state <= DMA_READ;
        DMA_READ: begin
          latch <= bus_data_i;
          state <= DMA_WRITE;
        end
        DMA_WRITE: begin
          cnt   <= cnt + 8'd1;
          state <= (cnt == LAST_CNT) ? DMA_IDLE : DMA_READ;
        end
        default: state <= DMA_IDLE;
      endcase
    end
  end

  always_comb begin
    dma_halt   = (state != DMA_IDLE);
    bus_rd     = 1'b0;
    bus_wr     = 1'b0;
    bus_addr   = 16'h0000;
    bus_data_o = 8'h00;
    case (state)
      DMA_READ: begin
        bus_rd   = 1'b1;
        bus_addr = {page, cnt};
      end
      DMA_WRITE: begin
        bus_wr     = 1'b1;
        bus_addr   = OAMDATA_ADDR;
        bus_data_o = latch;
      end
      default: ;
    endcase
  end

  // Reset has priority, so an interrupted transfer never reports completion.
  assign dma_done = cpu_en && !rst && (state == DMA_WRITE) && (cnt == LAST_CNT);

endmodule

// File: tb/tb_oam_dma.sv
// Randomised bench for oam_dma: CPU cycles are numbered from reset and every cycle's bus
// activity is predicted from the trigger cycle, its parity and a fixed memory pattern.
module tb_oam_dma;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic [15:0] reg_addr;
  logic        reg_wr;
  logic [7:0]  reg_data_i;
  logic [7:0]  bus_data_i;
  logic        dma_halt;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_data_o;
  logic        dma_done;

  oam_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_en     (cpu_en),
    .reg_addr   (reg_addr),
    .reg_wr     (reg_wr),
    .reg_data_i (reg_data_i),
    .bus_data_i (bus_data_i),
    .dma_halt   (dma_halt),
    .bus_addr   (bus_addr),
    .bus_rd     (bus_rd),
    .bus_wr     (bus_wr),
    .bus_data_o (bus_data_o),
    .dma_done   (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int done_seen;

  // Memory pattern: page $03 holds i^$5A at offset i.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h59;
  endfunction

  always_comb bus_data_i = mem_byte(bus_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input bit exp_done);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk);
    cpu_en = 1'b1;
    #1;
    if (dma_done === 1'b1) done_seen++;
    chk("dma_done", 32'(dma_done), 32'(exp_done));
    @(negedge clk);
    cpu_en = 1'b0;
    cyc++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_halt"}, 32'(dma_halt), 32'd0);
    chk({tag, "_rd"},   32'(bus_rd),   32'd0);
    chk({tag, "_wr"},   32'(bus_wr),   32'd0);
    chk({tag, "_addr"}, 32'(bus_addr), 32'd0);
  endtask

  task automatic idle_tick();
    check_idle("idle");
    tick(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // One transfer. rst_cnt: read index at which to reset (-1 none); stall_w: write index
  // to stall for 5 clks (-1 none); inject: second $4014 write mid-transfer.
  task automatic run_dma(input logic [7:0] pg, input int rst_cnt, input int stall_w, input bit inject);
    int t, align, first, last, k, i, halt_seen, exp_len;
    bit e_rd, e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_dat;
    check_idle("pre");
    done_seen = 0;
    halt_seen = 0;
    t = cyc;
    reg_wr = 1'b1; reg_addr = 16'h4014; reg_data_i = pg;
    tick(1'b0);
    reg_wr = 1'b0; reg_addr = 16'h0000; reg_data_i = 8'h00;
    align   = ((t + 1) % 2 == 0) ? 1 : 0;
    first   = t + 2 + align;
    last    = first + 511;
    exp_len = 513 + align;
    for (int n = t + 1; n <= last; n++) begin
      e_rd = 1'b0; e_wr = 1'b0; i = 0;
      if (n >= first) begin
        k    = n - first;
        i    = k / 2;
        e_rd = (k % 2 == 0);
        e_wr = (k % 2 == 1);
      end
      e_addr = e_rd ? {pg, 8'(i)} : (e_wr ? 16'h2004 : 16'h0000);
      e_dat  = e_wr ? mem_byte({pg, 8'(i)}) : 8'h00;
      if (dma_halt === 1'b1) halt_seen++;
      chk("halt", 32'(dma_halt), 32'd1);
      chk("rd",   32'(bus_rd),   32'(e_rd));
      chk("wr",   32'(bus_wr),   32'(e_wr));
      chk("addr", 32'(bus_addr), 32'(e_addr));
      chk("wdat", 32'(bus_data_o), 32'(e_dat));
      if (e_rd && i == rst_cnt) begin
        rst = 1'b1; cpu_en = 1'b1;
        #1;
        chk("rst_done", 32'(dma_done), 32'd0);
        @(negedge clk);
        rst = 1'b0; cpu_en = 1'b0;
        cyc = 0;
        check_idle("post_rst");
        return;
      end
      if (e_wr && i == stall_w) begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_wr",   32'(bus_wr),     32'd1);
          chk("stall_dat",  32'(bus_data_o), 32'(e_dat));
          chk("stall_halt", 32'(dma_halt),   32'd1);
        end
      end
      if (inject && n == first + 10) begin
        reg_wr = 1'b1; reg_addr = 16'h4014; reg_data_i = ~pg;
      end
      tick(n == last);
      reg_wr = 1'b0; reg_addr = 16'h0000; reg_data_i = 8'h00;
    end
    chk("halt_len", 32'(halt_seen), 32'(exp_len));
    chk("done_cnt", 32'(done_seen), 32'd1);
    check_idle("post");
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b0; reg_wr = 1'b0; reg_addr = 16'h0000; reg_data_i = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    check_idle("reset");
    chk("reset_dat",  32'(bus_data_o), 32'd0);
    chk("reset_done", 32'(dma_done),   32'd0);

    // Even trigger on cycle 10, then odd trigger.
    while (cyc < 10) idle_tick();
    run_dma(8'h02, -1, -1, 1'b0);
    while (cyc % 2 == 0) idle_tick();
    run_dma(8'h03, -1, -1, 1'b0);

    // Top page with a stall mid-write and an ignored second trigger.
    repeat ($urandom_range(0, 3)) idle_tick();
    run_dma(8'hFF, -1, 8'h80, 1'b1);

    // Reset during the read of byte $40, then a fresh transfer.
    run_dma(8'h11, 8'h40, -1, 1'b0);
    repeat ($urandom_range(1, 3)) idle_tick();
    run_dma(8'h22, -1, -1, 1'b0);

    // A non-trigger write while idle must not start anything.
    reg_wr = 1'b1; reg_addr = 16'h4015; reg_data_i = 8'h44;
    tick(1'b0);
    reg_wr = 1'b0; reg_addr = 16'h0000;
    check_idle("wrong_addr");

    repeat (3) begin
      repeat ($urandom_range(0, 4)) idle_tick();
      run_dma(8'($urandom_range(0, 255)), -1, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
